wb_ctl: RTL and testbench

- Write-back controller that drives the register file's single write port (we/wad/wd) from two result producers: the ALU and the memory/load unit.
- Each producer hands over results with a valid/ready handshake. Results queue in a small FIFO, and one entry is committed per cycle unless the port is held.
- A per-register pending-write scoreboard, set at issue and cleared at commit, gives the issue stage a busy vector for RAW hazard stalls.

---
 rtl/wb_ctl.sv | 150 +++++++++++++++
 tb/tb_wb_ctl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctl.sv
// wb_ctl: write-back controller for the register file's single write port.
// Results from the ALU and the load unit are arbitrated round-robin into a
// small FIFO and committed one per cycle unless wb_hold lends the port away.
// A per-register pending-write counter reports RAW hazards on busy.

`ifndef WIDTH
`define WIDTH 15
`endif
`ifndef RASB
`define RASB 3
`endif
`ifndef RAS
`define RAS 15
`endif

module wb_ctl #(
    parameter int DEPTH = 4,
    parameter int PCW   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_v,
    output logic               alu_rdy,
    input  logic [`RASB:0]     alu_ad,
    input  logic [`WIDTH:0]    alu_d,
    input  logic               mem_v,
    output logic               mem_rdy,
    input  logic [`RASB:0]     mem_ad,
    input  logic [`WIDTH:0]    mem_d,
    input  logic               iss_v,
    input  logic [`RASB:0]     iss_ad,
    output logic               iss_rdy,
    input  logic               wb_hold,
    output logic               we,
    output logic [`RASB:0]     wad,
    output logic [`WIDTH:0]    wd,
    output logic [`RAS:0]      busy,
    output logic               err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int NREG = `RAS + 1;
    localparam int RW   = `RASB + 1;
    localparam int DW   = `WIDTH + 1;
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [PCW-1:0] PEND_MAX = {PCW{1'b1}};

    logic [DW-1:0]   fifo_d  [DEPTH];
    logic [RW-1:0]   fifo_ad [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, empty;
    logic            rr_mem;        // 1: mem wins the next contested cycle
    logic            take_alu, take_mem, push;
    logic [RW-1:0]   push_ad;
    logic [DW-1:0]   push_d;
    logic [PCW-1:0]  pend [NREG];
    logic            iss_fire;
    logic [NREG-1:0] inc_vec, dec_vec;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Arbitration: a lone valid producer always wins; a tie goes to rr_mem.
    assign alu_rdy  = !full && (!mem_v || !rr_mem);
    assign mem_rdy  = !full && (!alu_v ||  rr_mem);
    assign take_alu = alu_v && alu_rdy;
    assign take_mem = mem_v && mem_rdy;
    assign push     = take_alu || take_mem;
    assign push_ad  = take_mem ? mem_ad : alu_ad;
    assign push_d   = take_mem ? mem_d  : alu_d;

    // Commit straight from the FIFO head; address and data are zeroed when idle.
    assign we  = !empty && !wb_hold;
    assign wad = we ? fifo_ad[rd_ptr] : '0;
    assign wd  = we ? fifo_d[rd_ptr]  : '0;

    // Round-robin pointer hands priority to the loser after each contested cycle.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values, independent of block ordering.
        if (rst)
            rr_mem <= 1'b1;
        else if (alu_v && mem_v && !full)
            rr_mem <= !rr_mem;
    end

    // FIFO storage: written on push, never cleared.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; the
        // occupancy count alone decides which entries are meaningful.
        if (push) begin
            fifo_d[wr_ptr]  <= push_d;
            fifo_ad[wr_ptr] <= push_ad;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (we)   rd_ptr <= rd_ptr + 1'b1;
            case ({push, we})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Scoreboard increment/decrement strobes, one-hot per register.
    assign iss_rdy  = (pend[iss_ad] != PEND_MAX);
    assign iss_fire = iss_v && iss_rdy;

    always_comb begin
        // NOTE: defaults first so no path leaves a bit unassigned (no latches).
        inc_vec = '0;
        dec_vec = '0;
        if (iss_fire) inc_vec[iss_ad] = 1'b1;
        if (we)       dec_vec[wad]    = 1'b1;
    end

    // Pending counters and the sticky error for commits to idle registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) pend[r] <= '0;
            err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    pend[r] <= pend[r] + 1'b1;
                else if (dec_vec[r] && !inc_vec[r] && pend[r] != '0)
                    pend[r] <= pend[r] - 1'b1;
            end
            if (we && pend[wad] == '0)
                err <= 1'b1;
        end
    end

    // Busy vector: any outstanding write to the register.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++) busy[r] = (pend[r] != '0);
    end

endmodule

// File: tb/tb_wb_ctl.sv
// tb_wb_ctl: directed self-checking bench for wb_ctl.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.

`ifndef WIDTH
`define WIDTH 15
`endif
`ifndef RASB
`define RASB 3
`endif
`ifndef RAS
`define RAS 15
`endif

module tb_wb_ctl;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_v, mem_v, iss_v, wb_hold;
    logic            alu_rdy, mem_rdy, iss_rdy;
    logic [`RASB:0]  alu_ad, mem_ad, iss_ad, wad;
    logic [`WIDTH:0] alu_d, mem_d, wd;
    logic            we, err;
    logic [`RAS:0]   busy;

    int n_tests = 0;
    int n_fail  = 0;

    wb_ctl #(.DEPTH(4), .PCW(3)) dut (
        .clk(clk), .rst(rst),
        .alu_v(alu_v), .alu_rdy(alu_rdy), .alu_ad(alu_ad), .alu_d(alu_d),
        .mem_v(mem_v), .mem_rdy(mem_rdy), .mem_ad(mem_ad), .mem_d(mem_d),
        .iss_v(iss_v), .iss_ad(iss_ad), .iss_rdy(iss_rdy),
        .wb_hold(wb_hold),
        .we(we), .wad(wad), .wd(wd), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then wait 1ns so outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs were just changed; let combinational outputs settle.
    task automatic settle();
        #1;
    endtask

    task automatic check_commit(input string tag, input logic e_we,
                                input logic [31:0] e_wad, input logic [31:0] e_wd);
        check({tag, ".we"},  32'(we),  32'(e_we));
        check({tag, ".wad"}, 32'(wad), e_wad);
        check({tag, ".wd"},  32'(wd),  e_wd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alu_v = 0; mem_v = 0; iss_v = 0; wb_hold = 0;
        alu_ad = '0; alu_d = '0; mem_ad = '0; mem_d = '0; iss_ad = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        settle();
        check_commit("rst", 1'b0, 0, 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.err", 32'(err), 0);
        check("rst.alu_rdy", 32'(alu_rdy), 1);
        check("rst.iss_rdy", 32'(iss_rdy), 1);

        // ---------------- 1: single ALU result, one-cycle latency ----------------
        alu_v = 1; alu_ad = 4'd2; alu_d = 16'h005A;
        iss_v = 1; iss_ad = 4'd2;
        settle();
        check("t1.alu_rdy", 32'(alu_rdy), 1);
        check_commit("t1.pre", 1'b0, 0, 0);
        tick();
        alu_v = 0; iss_v = 0;
        settle();
        check_commit("t1.commit", 1'b1, 2, 32'h5A);
        check("t1.busy", 32'(busy), 32'h0004);
        tick();
        check_commit("t1.idle", 1'b0, 0, 0);
        check("t1.busy_clr", 32'(busy), 0);
        check("t1.err", 32'(err), 0);

        // ---------------- 2: contested round-robin ----------------
        do_reset();
        alu_v = 1; alu_ad = 4'd4; alu_d = 16'h00A1;
        mem_v = 1; mem_ad = 4'd5; mem_d = 16'h00B1;
        settle();
        check("t2.c0.mem_rdy", 32'(mem_rdy), 1);
        check("t2.c0.alu_rdy", 32'(alu_rdy), 0);
        tick();                              // B1 accepted
        mem_d = 16'h00B2;
        settle();
        check("t2.c1.alu_rdy", 32'(alu_rdy), 1);
        check("t2.c1.mem_rdy", 32'(mem_rdy), 0);
        check_commit("t2.c1", 1'b1, 5, 32'hB1);
        tick();                              // A1 accepted
        alu_d = 16'h00A2;
        settle();
        check("t2.c2.mem_rdy", 32'(mem_rdy), 1);
        check("t2.c2.alu_rdy", 32'(alu_rdy), 0);
        check_commit("t2.c2", 1'b1, 4, 32'hA1);
        tick();                              // B2 accepted
        mem_d = 16'h00B3;
        settle();
        check("t2.c3.alu_rdy", 32'(alu_rdy), 1);
        check("t2.c3.mem_rdy", 32'(mem_rdy), 0);
        check_commit("t2.c3", 1'b1, 5, 32'hB2);
        tick();                              // A2 accepted
        alu_v = 0; mem_v = 0;
        settle();
        check_commit("t2.c4", 1'b1, 4, 32'hA2);
        tick();
        check_commit("t2.c5", 1'b0, 0, 0);

        // ---------------- 3: hold fills FIFO, release drains ----------------
        do_reset();
        wb_hold = 1; alu_v = 1; alu_ad = 4'd6;
        for (int i = 0; i < 4; i++) begin
            alu_d = 16'(16'h00C0 + i);
            settle();
            check($sformatf("t3.fill%0d.alu_rdy", i), 32'(alu_rdy), 1);
            check($sformatf("t3.fill%0d.we", i), 32'(we), 0);
            tick();
        end
        alu_d = 16'h00C4;
        settle();
        check("t3.full.alu_rdy", 32'(alu_rdy), 0);
        check("t3.full.we", 32'(we), 0);
        tick();
        check("t3.full2.alu_rdy", 32'(alu_rdy), 0);
        alu_v = 0; wb_hold = 0;
        settle();
        check_commit("t3.d0", 1'b1, 6, 32'hC0);
        check("t3.d0.alu_rdy", 32'(alu_rdy), 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_commit($sformatf("t3.d%0d", i), 1'b1, 6, 32'(32'hC0 + i));
            check($sformatf("t3.d%0d.alu_rdy", i), 32'(alu_rdy), 1);
        end
        tick();
        check_commit("t3.empty", 1'b0, 0, 0);

        // ---------------- 4: scoreboard on reg 1 ----------------
        do_reset();
        iss_v = 1; iss_ad = 4'd1;
        settle();
        check("t4.iss_rdy", 32'(iss_rdy), 1);
        tick();
        tick();                              // pend[1] = 2
        iss_v = 0;
        settle();
        check("t4.busy2", 32'(busy), 32'h0002);
        alu_v = 1; alu_ad = 4'd1; alu_d = 16'h0011;
        tick();
        alu_d = 16'h0012;
        tick();                              // first commit: pend 1
        alu_v = 0;
        settle();
        check("t4.busy1", 32'(busy), 32'h0002);
        check_commit("t4.c2", 1'b1, 1, 32'h12);
        tick();                              // second commit: pend 0
        check("t4.busy0", 32'(busy), 0);
        check("t4.we_idle", 32'(we), 0);
        iss_v = 1; iss_ad = 4'd1;
        tick();                              // pend 1
        iss_v = 0; alu_v = 1; alu_ad = 4'd1; alu_d = 16'h0013;
        tick();
        alu_v = 0; iss_v = 1; iss_ad = 4'd1;
        settle();
        check_commit("t4.same", 1'b1, 1, 32'h13);
        tick();                              // issue + commit: pend stays 1
        iss_v = 0;
        settle();
        check("t4.same.busy", 32'(busy), 32'h0002);
        alu_v = 1; alu_d = 16'h0014;
        tick();
        alu_v = 0;
        tick();                              // pend 0
        check("t4.final.busy", 32'(busy), 0);
        check("t4.err", 32'(err), 0);

        // ---------------- 5: counter saturation and err ----------------
        do_reset();
        iss_v = 1; iss_ad = 4'd3;
        for (int i = 0; i < 7; i++) begin
            settle();
            check($sformatf("t5.iss%0d.rdy", i), 32'(iss_rdy), 1);
            tick();
        end
        settle();
        check("t5.iss7.rdy", 32'(iss_rdy), 0);
        tick();                              // ignored
        iss_v = 0;
        settle();
        check("t5.sat.rdy", 32'(iss_rdy), 0);
        check("t5.sat.busy", 32'(busy), 32'h0008);
        alu_v = 1; alu_ad = 4'd3; alu_d = 16'h0033;
        tick();
        alu_v = 0;
        tick();                              // pend[3] = 6
        check("t5.dec.rdy", 32'(iss_rdy), 1);
        check("t5.dec.busy", 32'(busy), 32'h0008);
        check("t5.dec.err", 32'(err), 0);
        alu_v = 1; alu_ad = 4'd0; alu_d = 16'h0077;
        tick();
        alu_v = 0;
        settle();
        check_commit("t5.c0", 1'b1, 0, 32'h77);
        check("t5.pre.err", 32'(err), 0);
        tick();
        check("t5.err", 32'(err), 1);
        check("t5.busy0", 32'(busy), 32'h0008);
        tick();
        tick();
        check("t5.err.sticky", 32'(err), 1);

        // ---------------- 6: reset mid-operation ----------------
        wb_hold = 1;
        iss_v = 1; iss_ad = 4'd2;
        alu_v = 1; alu_ad = 4'd2; alu_d = 16'h0061;
        tick();
        alu_d = 16'h0062;
        tick();
        iss_v = 0; alu_d = 16'h0063;
        tick();
        alu_v = 0;
        settle();
        check("t6.busy", 32'(busy), 32'h000C);
        check("t6.held", 32'(we), 0);
        rst = 1;
        tick();
        rst = 0; wb_hold = 0;
        settle();
        check_commit("t6.after", 1'b0, 0, 0);
        check("t6.busy0", 32'(busy), 0);
        check("t6.err0", 32'(err), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t6.nowrite%0d", i), 32'(we), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
